fsm_vedacao: RTL
================

// Module: fsm_vedacao
// PURPOSE
//  Sealing-station controller; the consumer of the cork supply (sistema_rolhas) and producer for bottle counting (sistema_garrafas).
//  Detects a bottle at the station, stops the conveyor and waits for a cork.
//  Then pulses DECREMENTA_ROLHA, runs the sealing actuator for a fixed time, pulses INCREMENTA_GARRAFA and releases the bottle.
//  Halts the line on cork starvation or when the dozen limit is reached.
// PARAMETERS
//  CICLOS_VEDACAO  8     actuator on-time in clock cycles (>=1)
//  TIMEOUT_ROLHA   1000  max cycles in AGUARDA_ROLHA before alarm (only with VEDACAO_TIMEOUT_EN)
//  W_TIMER         16    timer width; must hold max(CICLOS_VEDACAO, TIMEOUT_ROLHA)
// PORTS
//  CLOCK               in   1  system clock
//  RESET               in   1  synchronous, active-high
//  ENABLE_LINHA        in   1  level; line allowed to run
//  SENSOR_GARRAFA      in   1  level; bottle present at station (already synchronised)
//  ROLHAS_DISPONIVEIS  in   1  from cork system; line counter non-zero
//  ALARME_SEM_ROLHA    in   1  from cork system; counter and dispenser both empty
//  LIMITE_DUZIAS       in   1  from bottle system; 10 dozens reached
//  DECREMENTA_ROLHA    out  1  1-cycle pulse; consumes one cork
//  INCREMENTA_GARRAFA  out  1  1-cycle pulse; one bottle sealed
//  MOTOR_ESTEIRA       out  1  conveyor run
//  ATUADOR_VEDACAO     out  1  sealing actuator on
//  ALARME_VEDACAO      out  1  sticky fault / halt indicator
//  ESTADO              out  3  current state encoding (debug/display)
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output and timer; state = IDLE.
//  - States and transitions (evaluated every rising CLOCK edge):
//    IDLE: MOTOR=0. If ENABLE_LINHA && !LIMITE_DUZIAS -> ESTEIRA.
//    ESTEIRA: MOTOR=1. If SENSOR_GARRAFA -> AGUARDA_ROLHA (MOTOR=0 from next cycle). If !ENABLE_LINHA -> IDLE.
//    AGUARDA_ROLHA: MOTOR=0; timer counts up. If ROLHAS_DISPONIVEIS -> VEDANDO, DECREMENTA_ROLHA=1 for that single cycle, timer cleared.
//      Else if ALARME_SEM_ROLHA -> FALHA.
//    VEDANDO: ATUADOR=1 for exactly CICLOS_VEDACAO cycles. Then -> LIBERA with INCREMENTA_GARRAFA=1 for one cycle.
//    LIBERA: MOTOR=1 until SENSOR_GARRAFA falls.
//      If ENABLE_LINHA && !LIMITE_DUZIAS -> ESTEIRA; else if LIMITE_DUZIAS -> CHEIO; else -> IDLE.
//    CHEIO: MOTOR=0, ALARME=1; exit only by RESET.
//    FALHA: MOTOR=0, ALARME=1. When ROLHAS_DISPONIVEIS -> AGUARDA_ROLHA, ALARME cleared (bottle still at station).
//  - Exactly one DECREMENTA_ROLHA per sealed bottle. Never asserted while ROLHAS_DISPONIVEIS=0.
//  - ROLHAS_DISPONIVEIS may lag the decrement by one cycle; it is sampled only in AGUARDA_ROLHA, which is >= CICLOS_VEDACAO+2 cycles later.
//  - ENABLE_LINHA drop or LIMITE_DUZIAS rise mid-bottle: the current bottle completes (seal + release) before the halt.
//  - SENSOR_GARRAFA glitch low during VEDANDO: ignored; sealing completes.
//  - RESET mid-operation: immediate return to IDLE; any pulse in flight is suppressed the same cycle.
//  - Timer saturates at 2^W_TIMER-1; no wrap.
// CONFIGURATION
//  VEDACAO_TIMEOUT_EN defined: if AGUARDA_ROLHA lasts TIMEOUT_ROLHA cycles without ROLHAS_DISPONIVEIS -> FALHA, even if ALARME_SEM_ROLHA=0.
//  Undefined: no timeout; FALHA is entered only via ALARME_SEM_ROLHA. Timer still used for VEDANDO.
// STRUCTURE
//  - Shared package linha_pkg: state encodings (IDLE=0 .. FALHA=6), default CICLOS_VEDACAO and TIMEOUT_ROLHA, and cork-system limits already used on the line.
//  - One sub-module, temporizador_vedacao: loadable up-counter with clear, saturate and terminal-count flag; shared by the sealing and timeout functions.
// TESTING
//  1. Reset, ENABLE_LINHA=1, bottle arrives, ROLHAS_DISPONIVEIS=1, CICLOS_VEDACAO=8
//     -> 1 DECREMENTA pulse, ATUADOR high 8 cycles, 1 INCREMENTA pulse, MOTOR resumes.
//  2. 12 bottles back-to-back -> exactly 12 DECREMENTA and 12 INCREMENTA pulses; no double pulses.
//  3. Bottle arrives with ROLHAS_DISPONIVEIS=0 and ALARME_SEM_ROLHA=1 -> FALHA, ALARME=1, MOTOR=0.
//     Restore rolhas -> seal completes, ALARME=0.
//  4. TIMEOUT_EN with TIMEOUT_ROLHA=20, rolhas=0, sem_rolha=0 -> FALHA at cycle 20. Without macro -> waits indefinitely.
//  5. LIMITE_DUZIAS rises during VEDANDO -> bottle sealed and released, then CHEIO, MOTOR=0 until RESET.
//  6. RESET asserted in cycle 3 of VEDANDO -> next cycle all outputs 0, ESTADO=IDLE, no INCREMENTA pulse.

Source files
------------

// File: rtl/linha_pkg.sv
// Shared definitions for the bottling line: sealing-station state encodings,
// default sealing parameters and cork-system limits.
package linha_pkg;

    typedef enum logic [2:0] {
        StIdle         = 3'd0,
        StEsteira      = 3'd1,
        StAguardaRolha = 3'd2,
        StVedando      = 3'd3,
        StLibera       = 3'd4,
        StCheio        = 3'd5,
        StFalha        = 3'd6
    } estado_t;

    localparam int unsigned CiclosVedacaoPadrao   = 8;
    localparam int unsigned TimeoutRolhaPadrao    = 1000;
    localparam int unsigned WTimerPadrao          = 16;

    // Cork-supply limits shared with sistema_rolhas and sistema_garrafas.
    localparam int unsigned CapacidadeRolhasLinha = 99;
    localparam int unsigned CapacidadeDispensador = 20;
    localparam int unsigned LimiteDuzias          = 10;

endpackage

// File: rtl/temporizador_vedacao.sv
// Loadable saturating up-counter with synchronous clear and a terminal-count flag
// (count >= limit). Shared by the sealing-time and cork-timeout functions.
module temporizador_vedacao #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q >= limit);

endmodule

// File: rtl/fsm_vedacao.sv
// Sealing-station controller: stops the conveyor at a bottle, consumes one cork,
// runs the sealing actuator and releases the bottle. Optional macro VEDACAO_TIMEOUT_EN
// adds a cork-wait timeout into FALHA.
module fsm_vedacao
    import linha_pkg::*;
#(
    parameter int unsigned CICLOS_VEDACAO = CiclosVedacaoPadrao,
    parameter int unsigned TIMEOUT_ROLHA  = TimeoutRolhaPadrao,
    parameter int unsigned W_TIMER        = WTimerPadrao
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       ENABLE_LINHA,
    input  logic       SENSOR_GARRAFA,
    input  logic       ROLHAS_DISPONIVEIS,
    input  logic       ALARME_SEM_ROLHA,
    input  logic       LIMITE_DUZIAS,
    output logic       DECREMENTA_ROLHA,
    output logic       INCREMENTA_GARRAFA,
    output logic       MOTOR_ESTEIRA,
    output logic       ATUADOR_VEDACAO,
    output logic       ALARME_VEDACAO,
    output logic [2:0] ESTADO
);

    localparam logic [W_TIMER-1:0] LimVedacao = W_TIMER'(CICLOS_VEDACAO - 1);
    localparam logic [W_TIMER-1:0] LimTimeout = W_TIMER'(TIMEOUT_ROLHA - 1);

    estado_t state_q, state_d;

    logic motor_d, atuador_d, alarme_d, decrementa_d, incrementa_d;
    logic timer_clr, timer_en, timer_tc;
    logic [W_TIMER-1:0] timer_limit;

    // Timer restarts on every state change, so it always counts cycles spent in
    // the current state.
    assign timer_clr   = (state_d != state_q);
    assign timer_en    = (state_q == StAguardaRolha) || (state_q == StVedando);
    assign timer_limit = (state_q == StVedando) ? LimVedacao : LimTimeout;

    temporizador_vedacao #(
        .W (W_TIMER)
    ) u_temporizador (
        .clk        (CLOCK),
        .rst        (RESET),
        .clr        (timer_clr),
        .load       (1'b0),
        .load_value ({W_TIMER{1'b0}}),
        .en         (timer_en),
        .limit      (timer_limit),
        .tc         (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ENABLE_LINHA && !LIMITE_DUZIAS) state_d = StEsteira;
            end
            StEsteira: begin
                if (SENSOR_GARRAFA)     state_d = StAguardaRolha;
                else if (!ENABLE_LINHA) state_d = StIdle;
            end
            StAguardaRolha: begin
                if (ROLHAS_DISPONIVEIS)    state_d = StVedando;
                else if (ALARME_SEM_ROLHA) state_d = StFalha;
`ifdef VEDACAO_TIMEOUT_EN
                else if (timer_tc)         state_d = StFalha;
`endif
            end
            StVedando: begin
                if (timer_tc) state_d = StLibera;
            end
            StLibera: begin
                // Enable/limit changes only take effect once the bottle has left.
                if (!SENSOR_GARRAFA) begin
                    if (ENABLE_LINHA && !LIMITE_DUZIAS) state_d = StEsteira;
                    else if (LIMITE_DUZIAS)             state_d = StCheio;
                    else                                state_d = StIdle;
                end
            end
            StCheio: begin
                state_d = StCheio;
            end
            StFalha: begin
                if (ROLHAS_DISPONIVEIS) state_d = StAguardaRolha;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered alongside the state, so they follow state_d.
    always_comb begin
        motor_d      = (state_d == StEsteira) || (state_d == StLibera);
        atuador_d    = (state_d == StVedando);
        alarme_d     = (state_d == StCheio) || (state_d == StFalha);
        decrementa_d = (state_q == StAguardaRolha) && (state_d == StVedando);
        incrementa_d = (state_q == StVedando) && (state_d == StLibera);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q            <= StIdle;
            MOTOR_ESTEIRA      <= 1'b0;
            ATUADOR_VEDACAO    <= 1'b0;
            ALARME_VEDACAO     <= 1'b0;
            DECREMENTA_ROLHA   <= 1'b0;
            INCREMENTA_GARRAFA <= 1'b0;
        end else begin
            state_q            <= state_d;
            MOTOR_ESTEIRA      <= motor_d;
            ATUADOR_VEDACAO    <= atuador_d;
            ALARME_VEDACAO     <= alarme_d;
            DECREMENTA_ROLHA   <= decrementa_d;
            INCREMENTA_GARRAFA <= incrementa_d;
        end
    end

    assign ESTADO = state_q;

endmodule
